// File: rtl/noc_credit_repeater.sv
// noc_credit_repeater: buffered credit-domain repeater between two NoC routers.
// Terminates the upstream credit loop in a local flit FIFO and runs an
// independent credit loop toward the downstream router.
// Optional statistics counters: define NOC_CREDIT_REPEATER_STATS_EN.
module noc_credit_repeater #(
  parameter int unsigned FLIT_WIDTH       = 128,
  parameter int unsigned DEST_WIDTH       = 6,
  parameter int unsigned BUFFER_DEPTH     = 4,
  parameter int unsigned DOWNSTREAM_DEPTH = 2,
  parameter int unsigned CNT_WIDTH        = $clog2(DOWNSTREAM_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [FLIT_WIDTH-1:0] data_in,
  input  logic [DEST_WIDTH-1:0] dest_in,
  input  logic                  is_tail_in,
  input  logic                  send_in,
  output logic                  credit_out,
  output logic [FLIT_WIDTH-1:0] data_out,
  output logic [DEST_WIDTH-1:0] dest_out,
  output logic                  is_tail_out,
  output logic                  send_out,
  input  logic                  credit_in,
  output logic                  overflow_err,
  output logic                  credit_err,
  output logic [31:0]           flit_count,
  output logic [31:0]           stall_count
);

  localparam int unsigned ENTRY_W = FLIT_WIDTH + DEST_WIDTH + 1;
  localparam int unsigned PTR_W   = (BUFFER_DEPTH > 1) ? $clog2(BUFFER_DEPTH) : 1;
  localparam int unsigned OCC_W   = $clog2(BUFFER_DEPTH + 1);
  localparam logic [PTR_W-1:0]     LAST_PTR = PTR_W'(BUFFER_DEPTH - 1);
  localparam logic [OCC_W-1:0]     FULL_OCC = OCC_W'(BUFFER_DEPTH);
  localparam logic [CNT_WIDTH-1:0] MAX_CRED = CNT_WIDTH'(DOWNSTREAM_DEPTH);

  logic [ENTRY_W-1:0]    mem [BUFFER_DEPTH];
  logic [PTR_W-1:0]      wr_ptr, wr_ptr_nxt;
  logic [PTR_W-1:0]      rd_ptr, rd_ptr_nxt;
  logic [OCC_W-1:0]      occ, occ_nxt;
  logic [CNT_WIDTH-1:0]  credits, credits_nxt;
  logic                  fifo_empty, fifo_full;
  logic                  push, pop;
  logic                  overflow_set, credit_err_set;
  logic [FLIT_WIDTH-1:0] head_data;
  logic [DEST_WIDTH-1:0] head_dest;
  logic                  head_tail;

  // Next-state for FIFO pointers, occupancy and downstream credit counter.
  always_comb begin
    fifo_empty     = (occ == '0);
    fifo_full      = (occ == FULL_OCC);
    push           = send_in && !fifo_full;
    pop            = !fifo_empty && (credits != '0);
    overflow_set   = send_in && fifo_full;
    credit_err_set = 1'b0;
    wr_ptr_nxt     = wr_ptr;
    rd_ptr_nxt     = rd_ptr;
    occ_nxt        = occ;
    credits_nxt    = credits;
    {head_data, head_dest, head_tail} = mem[rd_ptr];

    if (push) wr_ptr_nxt = (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PTR_W'(1);
    if (pop)  rd_ptr_nxt = (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PTR_W'(1);

    if (push && !pop)      occ_nxt = occ + OCC_W'(1);
    else if (!push && pop) occ_nxt = occ - OCC_W'(1);

    if (credit_in && !pop) begin
      if (credits == MAX_CRED) credit_err_set = 1'b1;
      else                     credits_nxt = credits + CNT_WIDTH'(1);
    end else if (!credit_in && pop) begin
      credits_nxt = credits - CNT_WIDTH'(1);
    end
  end

  // FIFO storage; contents need no reset since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {data_in, dest_in, is_tail_in};
  end

  // Control state, output register and sticky error flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      occ          <= '0;
      credits      <= MAX_CRED;
      send_out     <= 1'b0;
      credit_out   <= 1'b0;
      data_out     <= '0;
      dest_out     <= '0;
      is_tail_out  <= 1'b0;
      overflow_err <= 1'b0;
      credit_err   <= 1'b0;
    end else begin
      wr_ptr       <= wr_ptr_nxt;
      rd_ptr       <= rd_ptr_nxt;
      occ          <= occ_nxt;
      credits      <= credits_nxt;
      send_out     <= pop;
      credit_out   <= pop;
      overflow_err <= overflow_err | overflow_set;
      credit_err   <= credit_err | credit_err_set;
      if (pop) begin
        data_out    <= head_data;
        dest_out    <= head_dest;
        is_tail_out <= head_tail;
      end
    end
  end

`ifdef NOC_CREDIT_REPEATER_STATS_EN
  // Per-link statistics: forwarded flits and credit-starved cycles, wrapping.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      flit_count  <= '0;
      stall_count <= '0;
    end else begin
      if (send_out)                          flit_count  <= flit_count + 32'd1;
      if (!fifo_empty && (credits == '0))    stall_count <= stall_count + 32'd1;
    end
  end
`else
  // Statistics disabled: counters tied off.
  assign flit_count  = '0;
  assign stall_count = '0;
`endif

endmodule

// File: tb/tb_noc_credit_repeater.sv
// Directed, table-driven bench for noc_credit_repeater (default parameters).
module tb_noc_credit_repeater;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [127:0] data_in;
  logic [5:0]   dest_in;
  logic         is_tail_in;
  logic         send_in;
  logic         credit_out;
  logic [127:0] data_out;
  logic [5:0]   dest_out;
  logic         is_tail_out;
  logic         send_out;
  logic         credit_in;
  logic         overflow_err;
  logic         credit_err;
  logic [31:0]  flit_count;
  logic [31:0]  stall_count;

  noc_credit_repeater dut (
    .clk(clk), .rst_n(rst_n),
    .data_in(data_in), .dest_in(dest_in), .is_tail_in(is_tail_in), .send_in(send_in),
    .credit_out(credit_out),
    .data_out(data_out), .dest_out(dest_out), .is_tail_out(is_tail_out), .send_out(send_out),
    .credit_in(credit_in),
    .overflow_err(overflow_err), .credit_err(credit_err),
    .flit_count(flit_count), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         rst_n;
    logic         send;
    logic [127:0] data;
    logic [5:0]   dest;
    logic         tail;
    logic         cin;
    logic         e_send;
    logic         e_cout;
    logic [127:0] e_data;
    logic [5:0]   e_dest;
    logic         e_tail;
    logic         e_ov;
    logic         e_ce;
  } vec_t;

  localparam logic [127:0] DA = {4{32'hAAAA_0001}};
  localparam logic [127:0] DB = {4{32'hBBBB_0002}};
  localparam logic [127:0] DC = {4{32'hCCCC_0003}};
  localparam logic [127:0] DD = {4{32'hDDDD_0004}};
  localparam logic [127:0] DE = {4{32'hEEEE_0005}};

  int n_cmp = 0;
  int n_fail = 0;

  // Scoreboard state for the cycle-driven sequences.
  int cyc, up_cred, sent, rx, n_target, base, cout_cnt;
  bit pend [1024];

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic r, input logic s, input logic [127:0] d,
                              input logic [5:0] ds, input logic t, input logic ci,
                              input logic es, input logic eco, input logic [127:0] ed,
                              input logic [5:0] eds, input logic et, input logic eov,
                              input logic ece);
    vec_t v;
    v.rst_n = r; v.send = s; v.data = d; v.dest = ds; v.tail = t; v.cin = ci;
    v.e_send = es; v.e_cout = eco; v.e_data = ed; v.e_dest = eds; v.e_tail = et;
    v.e_ov = eov; v.e_ce = ece;
    return v;
  endfunction

  function automatic logic [127:0] fd(input int i);
    logic [31:0] w;
    w = (32'(i) * 32'h0101_0101) ^ 32'hA5A5_0000;
    return {w, ~w, w + 32'd1, w ^ 32'h0F0F_0F0F};
  endfunction

  function automatic logic [5:0] fdst(input int i);
    return 6'(i * 7 + 1);
  endfunction

  function automatic logic ftl(input int i);
    return (i % 3) == 2;
  endfunction

  task automatic clear_model();
    sent = 0; rx = 0; up_cred = 4; cout_cnt = 0;
    for (int i = 0; i < 1024; i++) pend[i] = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; send_in = 1'b0; credit_in = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    clear_model();
  endtask

  // One iteration per cycle: observe post-edge outputs, then drive next inputs.
  task automatic run(input int ncyc, input bit ret);
    for (int k = 0; k < ncyc; k++) begin
      if (credit_out) begin up_cred++; cout_cnt++; end
      if (send_out) begin
        check($sformatf("flit%0d", base + rx), 160'({data_out, dest_out, is_tail_out}),
              160'({fd(base + rx), fdst(base + rx), ftl(base + rx)}));
        rx++;
        if (ret && cyc + 2 < 1024) pend[cyc + 2] = 1'b1;
      end
      credit_in = pend[cyc];
      pend[cyc] = 1'b0;
      if (up_cred > 0 && sent < n_target) begin
        send_in = 1'b1; data_in = fd(base + sent); dest_in = fdst(base + sent);
        is_tail_in = ftl(base + sent);
        up_cred--; sent++;
      end else begin
        send_in = 1'b0;
      end
      @(posedge clk); #1;
      cyc++;
    end
    send_in = 1'b0; credit_in = 1'b0;
  endtask

  vec_t vecs [15];

  initial begin
    rst_n = 1'b0; send_in = 1'b0; credit_in = 1'b0;
    data_in = '0; dest_in = '0; is_tail_in = 1'b0;
    cyc = 0; base = 0; n_target = 0;
    clear_model();

    // rst, send, data, dest, tail, cin | send_out, credit_out, data, dest, tail, ov, ce
    vecs[0]  = mk(0, 0, '0, 0,  0, 0,   0, 0, '0, 0,  0, 0, 0);
    vecs[1]  = mk(1, 1, DA, 5,  0, 0,   0, 0, '0, 0,  0, 0, 0);
    vecs[2]  = mk(1, 0, '0, 0,  0, 0,   1, 1, DA, 5,  0, 0, 0);
    vecs[3]  = mk(1, 0, '0, 0,  0, 0,   0, 0, DA, 5,  0, 0, 0);
    vecs[4]  = mk(1, 1, DB, 3,  1, 0,   0, 0, DA, 5,  0, 0, 0);
    vecs[5]  = mk(1, 0, '0, 0,  0, 1,   1, 1, DB, 3,  1, 0, 0);
    vecs[6]  = mk(1, 0, '0, 0,  0, 1,   0, 0, DB, 3,  1, 0, 0);
    vecs[7]  = mk(1, 0, '0, 0,  0, 1,   0, 0, DB, 3,  1, 0, 1);
    vecs[8]  = mk(1, 0, '0, 0,  0, 0,   0, 0, DB, 3,  1, 0, 1);
    vecs[9]  = mk(1, 1, DC, 10, 0, 0,   0, 0, DB, 3,  1, 0, 1);
    vecs[10] = mk(1, 1, DD, 20, 1, 0,   1, 1, DC, 10, 0, 0, 1);
    vecs[11] = mk(1, 1, DE, 33, 0, 0,   1, 1, DD, 20, 1, 0, 1);
    vecs[12] = mk(1, 0, '0, 0,  0, 0,   0, 0, DD, 20, 1, 0, 1);
    vecs[13] = mk(1, 0, '0, 0,  0, 0,   0, 0, DD, 20, 1, 0, 1);
    vecs[14] = mk(1, 0, '0, 0,  0, 0,   0, 0, DD, 20, 1, 0, 1);

    #2;
    for (int i = 0; i < 15; i++) begin
      rst_n = vecs[i].rst_n; send_in = vecs[i].send; data_in = vecs[i].data;
      dest_in = vecs[i].dest; is_tail_in = vecs[i].tail; credit_in = vecs[i].cin;
      @(posedge clk); #1;
      check($sformatf("vec%0d", i),
            160'({send_out, credit_out, data_out, dest_out, is_tail_out, overflow_err, credit_err}),
            160'({vecs[i].e_send, vecs[i].e_cout, vecs[i].e_data, vecs[i].e_dest,
                  vecs[i].e_tail, vecs[i].e_ov, vecs[i].e_ce}));
    end
    send_in = 1'b0; credit_in = 1'b0;

    // Stream of 8 flits with credits returned two cycles after each send_out.
    do_reset(); base = 0; n_target = 8;
    run(60, 1'b1);
    check("stream_rx", 160'(rx), 160'(8));
    check("stream_errs", 160'({overflow_err, credit_err}), 160'(0));
`ifdef NOC_CREDIT_REPEATER_STATS_EN
    check("stream_flit_count", 160'(flit_count), 160'(8));
`else
    check("stream_flit_count", 160'(flit_count), 160'(0));
`endif

    // No downstream credits returned: only two flits leave, four stay buffered.
    do_reset(); base = 20; n_target = 6;
    run(20, 1'b0);
    check("stall_sent", 160'(sent), 160'(6));
    check("stall_rx", 160'(rx), 160'(2));
    check("stall_ov", 160'(overflow_err), 160'(0));
`ifdef NOC_CREDIT_REPEATER_STATS_EN
    check("stall_count_nz", 160'(stall_count != 32'd0), 160'(1));
`else
    check("stall_count_off", 160'({flit_count, stall_count}), 160'(0));
`endif
    pend[cyc] = 1'b1; pend[cyc + 1] = 1'b1;
    run(40, 1'b1);
    check("stall_drain_rx", 160'(rx), 160'(6));
    check("stall_drain_errs", 160'({overflow_err, credit_err}), 160'(0));

    // Overflow: credits exhausted, fifth buffered write is dropped.
    do_reset(); base = 40; n_target = 7; up_cred = 100;
    run(6, 1'b0);
    check("ovf_before", 160'(overflow_err), 160'(0));
    run(1, 1'b0);
    check("ovf_set", 160'(overflow_err), 160'(1));
    run(5, 1'b0);
    check("ovf_sticky", 160'(overflow_err), 160'(1));
    pend[cyc] = 1'b1; pend[cyc + 1] = 1'b1;
    run(40, 1'b1);
    check("ovf_drain_rx", 160'(rx), 160'(6));
    check("ovf_drain_errs", 160'({overflow_err, credit_err}), 160'({1'b1, 1'b0}));

    // Reset with three flits buffered: everything discarded.
    do_reset(); base = 60; n_target = 5;
    run(10, 1'b0);
    check("rst_pre_rx", 160'(rx), 160'(2));
    check("rst_pre_sent", 160'(sent), 160'(5));
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("rst_outputs",
          160'({send_out, credit_out, data_out, dest_out, is_tail_out, overflow_err, credit_err}),
          160'(0));
    check("rst_counters", 160'({flit_count, stall_count}), 160'(0));
    rst_n = 1'b1;
    clear_model(); base = 80; n_target = 0;
    run(10, 1'b1);
    check("rst_no_send", 160'(rx), 160'(0));
    check("rst_no_credit", 160'(cout_cnt), 160'(0));
    n_target = 1;
    run(6, 1'b1);
    check("rst_new_flit", 160'(rx), 160'(1));

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
